// File: rtl/fifo_proc_pkg.sv
// fifo_proc_pkg: shared types and default parameters for the processing FIFO.
//   proc_mode_t : per-entry operation applied by every pipeline stage
//   DEF_*       : default parameter values used by fifo_proc_pipe
package fifo_proc_pkg;

  typedef enum logic {
    MODE_SUB = 1'b0,
    MODE_ADD = 1'b1
  } proc_mode_t;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_FIFO_WIDTH = 11;
  localparam int DEF_NUM_LOOPS  = 3;
  localparam int DEF_STEP       = 1;
  localparam int DEF_SATURATE   = 0;
  localparam int DEF_AE_THRESH  = 2;

endpackage

// File: rtl/fifo_proc_stage.sv
// fifo_proc_stage: one registered add/sub stage of the processing pipeline.
//   clk, rstn          : clock, async active-low reset
//   in_vld/in_mode/in_data    : entry entering the stage
//   out_vld/out_mode/out_data : registered entry, data moved by +/-STEP
// Data and mode only update on a valid entry, so out_data holds its last
// result while idle.
module fifo_proc_stage
  import fifo_proc_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int STEP       = DEF_STEP,
  parameter int SATURATE   = DEF_SATURATE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_vld,
  input  proc_mode_t            in_mode,
  input  logic [FIFO_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output proc_mode_t            out_mode,
  output logic [FIFO_WIDTH-1:0] out_data
);

  // One extra bit exposes carry (add) or borrow (sub).
  localparam logic [FIFO_WIDTH:0] STEP_X = {1'b0, FIFO_WIDTH'(STEP)};

  logic [FIFO_WIDTH:0]   sum, dif;
  logic [FIFO_WIDTH-1:0] nxt;

  always_comb begin
    sum = {1'b0, in_data} + STEP_X;
    dif = {1'b0, in_data} - STEP_X;
    nxt = '0;
    if (in_mode == MODE_ADD)
      nxt = (SATURATE != 0 && sum[FIFO_WIDTH]) ? '1 : sum[FIFO_WIDTH-1:0];
    else
      nxt = (SATURATE != 0 && dif[FIFO_WIDTH]) ? '0 : dif[FIFO_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_mode <= MODE_SUB;
      out_data <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_mode <= in_mode;
        out_data <= nxt;
      end
    end
  end

endmodule

// File: rtl/fifo_proc_pipe.sv
// fifo_proc_pipe: synchronous FIFO of {mode,data} entries; every accepted pop
// runs the head entry through NUM_LOOPS add/sub stages.
//   clk, rstn                       : clock, async active-low reset
//   push, push_data, push_mode      : write request (mode 1 = add, 0 = sub)
//   pop                             : read request
//   pop_data, pop_valid             : processed result, NUM_LOOPS cycles after pop
//   empty, full, almost_full, almost_empty, count : occupancy status
//   overflow_err, underflow_err     : sticky misuse flags, cleared by reset only
module fifo_proc_pipe
  import fifo_proc_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_LOOPS  = DEF_NUM_LOOPS,
  parameter int STEP       = DEF_STEP,
  parameter int SATURATE   = DEF_SATURATE,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            push,
  input  logic [FIFO_WIDTH-1:0]           push_data,
  input  logic                            push_mode,
  input  logic                            pop,
  output logic [FIFO_WIDTH-1:0]           pop_data,
  output logic                            pop_valid,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow_err,
  output logic                            underflow_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  // Entry layout: {mode, data}
  logic [FIFO_DEPTH-1:0][FIFO_WIDTH:0] mem;
  logic [AW-1:0] wptr, rptr;
  logic          push_acc, pop_acc;

  assign empty        = (count == '0);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A simultaneous push+pop is judged against the start-of-cycle count, so
  // at full only the pop goes through and at empty only the push does.
  assign push_acc = push && !full;
  assign pop_acc  = pop  && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem           <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_acc) begin
        mem[wptr] <= {push_mode, push_data};
        wptr      <= wptr + 1'b1;
      end
      if (pop_acc)
        rptr <= rptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full)  overflow_err  <= 1'b1;
      if (pop  && empty) underflow_err <= 1'b1;
    end
  end

  // Index 0 is the entry leaving the FIFO this cycle; index k+1 is the
  // registered output of stage k.
  logic       [NUM_LOOPS:0]                 vld_pipe;
  proc_mode_t [NUM_LOOPS:0]                 mode_pipe;
  logic       [NUM_LOOPS:0][FIFO_WIDTH-1:0] data_pipe;

  assign vld_pipe[0]  = pop_acc;
  assign mode_pipe[0] = proc_mode_t'(mem[rptr][FIFO_WIDTH]);
  assign data_pipe[0] = mem[rptr][FIFO_WIDTH-1:0];

  for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_stage
    fifo_proc_stage #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .STEP       (STEP),
      .SATURATE   (SATURATE)
    ) u_stage (
      .clk      (clk),
      .rstn     (rstn),
      .in_vld   (vld_pipe[k]),
      .in_mode  (mode_pipe[k]),
      .in_data  (data_pipe[k]),
      .out_vld  (vld_pipe[k+1]),
      .out_mode (mode_pipe[k+1]),
      .out_data (data_pipe[k+1])
    );
  end

  assign pop_valid = vld_pipe[NUM_LOOPS];
  assign pop_data  = data_pipe[NUM_LOOPS];

  // The mode leaving the last stage has no consumer.
  logic unused_mode;
  assign unused_mode = mode_pipe[NUM_LOOPS];

endmodule

// File: tb/tb_fifo_proc_pipe.sv
// tb_fifo_proc_pipe: directed bench for fifo_proc_pipe with defaults
// (depth 8, width 11, 3 stages, step 1). A second instance with SATURATE=1
// sees identical stimulus; only its results are checked in the clamp tests.
module tb_fifo_proc_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        push = 1'b0;
  logic [10:0] push_data = '0;
  logic        push_mode = 1'b0;
  logic        pop = 1'b0;

  logic [10:0] pop_data;
  logic        pop_valid, empty, full, almost_full, almost_empty;
  logic [3:0]  count;
  logic        overflow_err, underflow_err;

  logic [10:0] s_pop_data;
  logic        s_pop_valid, s_empty, s_full, s_almost_full, s_almost_empty;
  logic [3:0]  s_count;
  logic        s_overflow_err, s_underflow_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_proc_pipe dut (
    .clk(clk), .rstn(rstn), .push(push), .push_data(push_data),
    .push_mode(push_mode), .pop(pop), .pop_data(pop_data),
    .pop_valid(pop_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  fifo_proc_pipe #(.SATURATE(1)) dut_s (
    .clk(clk), .rstn(rstn), .push(push), .push_data(push_data),
    .push_mode(push_mode), .pop(pop), .pop_data(s_pop_data),
    .pop_valid(s_pop_valid), .empty(s_empty), .full(s_full),
    .almost_full(s_almost_full), .almost_empty(s_almost_empty), .count(s_count),
    .overflow_err(s_overflow_err), .underflow_err(s_underflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1ns later, then idle.
  task automatic step(input logic ps, input logic [10:0] pd, input logic pm, input logic pp);
    push = ps; push_data = pd; push_mode = pm; pop = pp;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [10:0] exp3 [8];

  initial begin
    // data ± 3: even entries add, odd entries subtract
    exp3 = '{11'd3, 11'h7FE, 11'd5, 11'd0, 11'd7, 11'd2, 11'd9, 11'd4};

    // Reset state
    #3;
    chk("rst_pop_data", pop_data, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {empty, full, almost_empty, almost_full}, 4'b1010);
    chk("rst_errs", {overflow_err, underflow_err}, 2'b00);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle();

    // 1: latency, 5 + 3 = 8
    step(1'b1, 11'd5, 1'b1, 1'b0);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    chk("t1_vld_T1", pop_valid, 0);
    idle();
    chk("t1_vld_T2", pop_valid, 0);
    idle();
    chk("t1_vld_T3", pop_valid, 1);
    chk("t1_data", pop_data, 11'd8);
    idle();
    chk("t1_vld_after", pop_valid, 0);
    chk("t1_data_hold", pop_data, 11'd8);

    // 2: wrap vs clamp
    step(1'b1, 11'd2, 1'b0, 1'b0);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    idle(); idle();
    chk("t2_sub_wrap", pop_data, 11'h7FF);
    chk("t2_sub_sat", s_pop_data, 11'h000);
    chk("t2_sat_vld", s_pop_valid, 1);
    step(1'b1, 11'h7FE, 1'b1, 1'b0);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    idle(); idle();
    chk("t2_add_sat", s_pop_data, 11'h7FF);
    chk("t2_add_wrap", pop_data, 11'h001);

    // 3: fill, flags, overflow, back-to-back drain
    chk("t3_start_empty", empty, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 11'(i), ~i[0], 1'b0);
      chk("t3_count", count, i + 1);
      chk("t3_almost_full", almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("t3_full", full, (i + 1 == 8) ? 1 : 0);
      chk("t3_almost_empty", almost_empty, (i + 1 <= 2) ? 1 : 0);
    end
    chk("t3_ovf_pre", overflow_err, 0);
    step(1'b1, 11'd99, 1'b1, 1'b0);
    chk("t3_count_9th", count, 8);
    chk("t3_ovf", overflow_err, 1);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 11'd0, 1'b0, (i < 8));
      if (i >= 2 && i <= 9) begin
        chk("t3_drain_vld", pop_valid, 1);
        chk("t3_drain_data", pop_data, exp3[i-2]);
      end else begin
        chk("t3_drain_novld", pop_valid, 0);
      end
    end
    chk("t3_empty_end", empty, 1);

    // 4: underflow
    chk("t4_udf_pre", underflow_err, 0);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_novld", pop_valid, 0);
      chk("t4_count", count, 0);
      idle();
    end
    chk("t4_udf", underflow_err, 1);
    step(1'b1, 11'd7, 1'b1, 1'b0);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    idle(); idle();
    chk("t4_traffic_data", pop_data, 11'd10);
    chk("t4_udf_sticky", underflow_err, 1);

    // 5: simultaneous push+pop at count 4 and at empty
    for (int i = 0; i < 4; i++) step(1'b1, 11'(10 + i), 1'b1, 1'b0);
    step(1'b1, 11'd20, 1'b1, 1'b1);
    chk("t5_count_4", count, 4);
    idle();
    idle();
    chk("t5_head_vld", pop_valid, 1);
    chk("t5_head_data", pop_data, 11'd13);
    for (int i = 0; i < 4; i++) step(1'b0, 11'd0, 1'b0, 1'b1);
    idle(); idle();
    chk("t5_last_data", pop_data, 11'd23);
    chk("t5_empty", empty, 1);
    step(1'b1, 11'd30, 1'b1, 1'b1);
    chk("t5_count_1", count, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_empty_novld", pop_valid, 0);
      idle();
    end
    chk("t5_udf", underflow_err, 1);

    // 6: async reset with pops in flight
    step(1'b1, 11'd31, 1'b1, 1'b0);
    step(1'b1, 11'd32, 1'b1, 1'b0);
    chk("t6_count_3", count, 3);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    chk("t6_inflight_vld", pop_valid, 1);
    chk("t6_inflight_data", pop_data, 11'd33);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_vld", pop_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_errs", {overflow_err, underflow_err}, 2'b00);
    chk("t6_rst_empty", empty, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("t6_no_stale_vld", pop_valid, 0);
    end
    chk("t6_count_after", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
